ifft_8point: RTL and testbench
==============================

Name: ifft_8point

Overview:
- Inverse counterpart of the team's 8-point FFT. Accepts one 8-point frequency-domain frame as serial complex samples X[0..7] and computes the radix-2 DIT inverse DFT with built-in 1/8 scaling.
- Streams out time-domain samples x[0..7] in natural order.
- Sits after the FFT/processing path so that spectra can be returned to the sample domain.

Parameters:
- N, 8, width of the signed two's-complement input and output real/imag samples.
- G, 3, guard bits on the internal datapath; internal width is N+G.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clear  input  1  asynchronous, active-high reset.
- in_valid  input  1  input sample is valid this cycle.
- in_r  input  N  real part of X[k], signed.
- in_im  input  N  imaginary part of X[k], signed.
- in_ready  output  1  block accepts a sample this cycle; high only in LOAD.
- out_valid  output  1  out_r/out_im carry x[out_idx].
- out_r  output  N  real part of x[n], signed.
- out_im  output  N  imaginary part of x[n], signed.
- out_idx  output  3  time index n of the current output.
- busy  output  1  high in COMPUTE and UNLOAD.

Behaviour:
- Reset (clear=1, async): state=LOAD; in_cnt=0; bfly_cnt=0; out_cnt=0. Outputs: in_ready=1, out_valid=0, out_r=0, out_im=0, out_idx=0, busy=0. Sample memory contents are don't-care.
- Handshake: a sample is accepted when in_valid && in_ready.
  - The k-th accepted sample (k=0..7) is sign-extended to N+G bits and written at bit-reversed address rev3(k).
- LOAD:
  - in_ready=1.
  - Counts accepts on in_cnt; in_valid=0 cycles hold the count.
  - The 8th accept moves to COMPUTE on the next edge.
- COMPUTE: 12 cycles, one butterfly per cycle; in_ready=0, busy=1.
  - Stage s=0,1,2 has span h=1,2,4 and 4 butterflies.
  - Butterfly on (p, q=p+h) with twiddle W = exp(+j*2*pi*m/8), m = (p mod h)*(4/h).
  - Computes t = W*mem[q]; mem[p] <= (mem[p]+t)>>>1; mem[q] <= (mem[p]-t)>>>1. The shift is arithmetic (floor).
  - Twiddle multiply rules:
    - m=0: t = mem[q].
    - m=2: t = j*mem[q], done by swap/negate with no multiplier error.
    - m=1,3: use c=181, products >>>8, with cos=+c/256 and sin=+c/256 for m=1, cos=-c/256 for m=3.
  - After butterfly 11 the state moves to UNLOAD.
- UNLOAD: 8 cycles; busy=1, out_valid=1.
  - out_idx = out_cnt = 0..7; out = mem[out_cnt] saturated to N bits (clip at +2^(N-1)-1 and -2^(N-1)).
  - After out_idx=7: next state is LOAD, with out_valid=0 and busy=0 in that cycle.
- Latency: the first out_valid occurs 13 cycles after the edge that accepted the 8th sample (12 compute cycles plus 1 registered output). Outputs are registered.
- Throughput: one frame per 8+12+8 cycles minimum. Input is not accepted during COMPUTE or UNLOAD; upstream must hold in_valid until in_ready.
- Boundaries:
  - in_valid asserted outside LOAD is ignored, with no state change.
  - clear asserted mid-frame in any state aborts the frame immediately. No partial output is emitted and the next frame starts at k=0.
  - Overall scaling is 1/8 via three halvings; rounding is floor at every stage.

Test Plan:
- Impulse: X[0]=(8,0), X[1..7]=(0,0) -> 8 outputs, all (1,0), out_idx 0..7, first out_valid exactly 13 cycles after the 8th accept.
- DC spectrum: all X[k]=(8,0) -> x[0]=(8,0), x[1..7]=(0,0).
- Single bin: X[2]=(8,0), others 0 -> x = (1,0),(0,1),(-1,0),(0,-1) repeating over n=0..7, with exact values.
- Input gaps: same impulse frame with in_valid deasserted for 3 cycles between samples 3 and 4 -> identical outputs; in_ready stays low for the 20 cycles of COMPUTE+UNLOAD.
- Mid-frame reset: clear pulsed after 5 accepts, then a full DC frame -> no out_valid before the new frame; result matches the DC case.
- Saturation/round-trip: X[k] equal to the FFT of x=[4,1,2,-3,1,-2,0,3] (from the FFT model) -> outputs within ±1 LSB of x×(1/8)×8 ordering; X[0]=(127,0) with X[4]=(-128,0) -> no wrap, outputs within signed 8-bit range.

Source files
------------

// File: rtl/ifft_8point.sv
// ifft_8point: 8-point radix-2 DIT inverse FFT with 1/8 scaling.
// Serial bit-reversed load, one butterfly per cycle, natural-order unload.
module ifft_8point #(
    parameter int N = 8,
    parameter int G = 3
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                in_valid,
    input  logic signed [N-1:0] in_r,
    input  logic signed [N-1:0] in_im,
    output logic                in_ready,
    output logic                out_valid,
    output logic signed [N-1:0] out_r,
    output logic signed [N-1:0] out_im,
    output logic [2:0]          out_idx,
    output logic                busy
);
    localparam int W = N + G;
    localparam int P = W + 10;
    localparam logic signed [P-1:0] C = 181;

    typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

    state_t              state;
    logic [2:0]          in_cnt;
    logic [2:0]          out_cnt;
    logic [3:0]          bfly_cnt;
    logic signed [W-1:0] mem_r [8];
    logic signed [W-1:0] mem_i [8];

    logic [1:0]          stage;
    logic [1:0]          bsel;
    logic [2:0]          p_idx;
    logic [2:0]          q_idx;
    logic [2:0]          rev;
    logic [1:0]          m;
    logic signed [P-1:0] pr;
    logic signed [P-1:0] pim;
    logic signed [P-1:0] qr;
    logic signed [P-1:0] qim;
    logic signed [P-1:0] cs;
    logic signed [P-1:0] tr;
    logic signed [P-1:0] tim;

    assign stage = bfly_cnt[3:2];
    assign bsel  = bfly_cnt[1:0];
    assign rev   = {in_cnt[0], in_cnt[1], in_cnt[2]};

    // Pair addresses and twiddle index: stage s inserts a 0/1 at bit s
    always_comb begin
        p_idx = {bsel, 1'b0};
        q_idx = {bsel, 1'b1};
        m     = 2'd0;
        case (stage)
            2'd1: begin
                p_idx = {bsel[1], 1'b0, bsel[0]};
                q_idx = {bsel[1], 1'b1, bsel[0]};
                m     = {bsel[0], 1'b0};
            end
            2'd2: begin
                p_idx = {1'b0, bsel};
                q_idx = {1'b1, bsel};
                m     = bsel;
            end
            default: ;
        endcase
    end

    // Twiddle product t = W^m * mem[q]; j*q is an exact swap/negate
    always_comb begin
        pr  = P'(mem_r[p_idx]);
        pim = P'(mem_i[p_idx]);
        qr  = P'(mem_r[q_idx]);
        qim = P'(mem_i[q_idx]);
        cs  = (m == 2'd3) ? -C : C;
        tr  = qr;
        tim = qim;
        case (m)
            2'd2: begin
                tr  = -qim;
                tim = qr;
            end
            2'd1, 2'd3: begin
                tr  = ((qr * cs) >>> 8) - ((qim * C) >>> 8);
                tim = ((qr * C) >>> 8) + ((qim * cs) >>> 8);
            end
            default: ;
        endcase
    end

    function automatic logic signed [N-1:0] sat(input logic signed [W-1:0] v);
        if ((&v[W-1:N-1]) || (~|v[W-1:N-1]))
            return v[N-1:0];
        else if (v[W-1])
            return {1'b1, {(N-1){1'b0}}};
        else
            return {1'b0, {(N-1){1'b1}}};
    endfunction

    // Sample memory: bit-reversed load, then in-place halving butterflies
    always_ff @(posedge clk) begin
        if (state == LOAD && in_valid) begin
            mem_r[rev] <= W'(in_r);
            mem_i[rev] <= W'(in_im);
        end else if (state == COMPUTE) begin
            mem_r[p_idx] <= W'((pr + tr) >>> 1);
            mem_i[p_idx] <= W'((pim + tim) >>> 1);
            mem_r[q_idx] <= W'((pr - tr) >>> 1);
            mem_i[q_idx] <= W'((pim - tim) >>> 1);
        end
    end

    // Frame sequencing with registered handshake and output signals
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state     <= LOAD;
            in_cnt    <= 3'd0;
            bfly_cnt  <= 4'd0;
            out_cnt   <= 3'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_r     <= '0;
            out_im    <= '0;
            out_idx   <= 3'd0;
            busy      <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    out_valid <= 1'b0;
                    if (in_valid) begin
                        in_cnt <= in_cnt + 3'd1;
                        if (in_cnt == 3'd7) begin
                            state    <= COMPUTE;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    bfly_cnt <= bfly_cnt + 4'd1;
                    if (bfly_cnt == 4'd11) begin
                        bfly_cnt <= 4'd0;
                        state    <= UNLOAD;
                    end
                end
                UNLOAD: begin
                    out_valid <= 1'b1;
                    out_r     <= sat(mem_r[out_cnt]);
                    out_im    <= sat(mem_i[out_cnt]);
                    out_idx   <= out_cnt;
                    out_cnt   <= out_cnt + 3'd1;
                    if (out_cnt == 3'd7) begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_ifft_8point.sv
// Testbench for ifft_8point: hand vectors, handshake corner cases,
// and random frames against an integer DIT model and an ideal IDFT.
module tb_ifft_8point;
    logic              clk = 1'b0;
    logic              clear;
    logic              in_valid;
    logic signed [7:0] in_r;
    logic signed [7:0] in_im;
    logic              in_ready;
    logic              out_valid;
    logic signed [7:0] out_r;
    logic signed [7:0] out_im;
    logic [2:0]        out_idx;
    logic              busy;

    ifft_8point #(.N(8), .G(3)) dut (
        .clk(clk), .clear(clear), .in_valid(in_valid),
        .in_r(in_r), .in_im(in_im), .in_ready(in_ready),
        .out_valid(out_valid), .out_r(out_r), .out_im(out_im),
        .out_idx(out_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0][7:0] xr;
        logic [7:0][7:0] xi;
        logic [7:0][7:0] er;
        logic [7:0][7:0] ei;
    } vec_t;

    vec_t tbl [4];
    int npass = 0;
    int ntot  = 0;
    int sr [8];
    int si [8];
    int gr [8];
    int gi [8];
    int mr [8];
    int mi [8];
    int sb_r [8] = '{1, 0, -1, 0, 1, 0, -1, 0};
    int sb_i [8] = '{0, 1, 0, -1, 0, 1, 0, -1};
    int rt_r [8] = '{6, 9, 3, -3, 8, -3, 3, 9};
    int rt_i [8] = '{0, 0, 1, 4, 0, -4, -1, 0};
    int rt_x [8] = '{4, 1, 2, -3, 1, -2, 0, 3};

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        ntot++;
        if (got == exp) npass++;
        else $display("FAIL %s: got %0d, want %0d", nm, got, exp);
    endtask

    // Offer n_send samples; optional idle gap after sample gap_at
    task automatic send(input int gap_at, input int gap_len, input int n_send);
        int w;
        for (int k = 0; k < n_send; k++) begin
            in_valid = 1'b1;
            in_r = 8'(sr[k]);
            in_im = 8'(si[k]);
            w = 0;
            while (!in_ready && w < 50) begin
                step;
                w++;
            end
            if (!in_ready) begin
                ntot++;
                $display("FAIL in_ready_wait: got 0, want 1");
            end
            step;
            if (k == gap_at) begin
                in_valid = 1'b0;
                repeat (gap_len) step;
            end
        end
        in_valid = 1'b0;
    endtask

    // Called right after the 8th accept; gathers the 8 outputs
    task automatic collect(input bit junk);
        int got_n;
        int cyc;
        int first;
        bit ir_ok;
        got_n = 0;
        cyc = 0;
        first = -1;
        ir_ok = (in_ready == 1'b0);
        while (got_n < 8 && cyc < 60) begin
            if (junk) begin
                in_valid = 1'b1;
                in_r = 8'($urandom);
                in_im = 8'($urandom);
            end
            step;
            cyc++;
            if (cyc < 20 && in_ready) ir_ok = 1'b0;
            if (out_valid) begin
                if (first < 0) first = cyc;
                chk("out_idx", int'(out_idx), got_n);
                gr[got_n] = out_r;
                gi[got_n] = out_im;
                got_n++;
            end
        end
        in_valid = 1'b0;
        if (got_n < 8) begin
            ntot++;
            $display("FAIL out_timeout: got %0d outputs, want 8", got_n);
        end
        chk("latency", first, 13);
        chk("in_ready_low", int'(ir_ok), 1);
        chk("in_ready_back", int'(in_ready), 1);
        step;
        chk("out_valid_drop", int'(out_valid), 0);
    endtask

    // Reference: bit-reverse, three halving DIT stages on integers
    task automatic model;
        int ar [8];
        int ai [8];
        int h, m, q, qr, qi, tr, ti, cs, p_r, p_i;
        for (int k = 0; k < 8; k++) begin
            ar[((k & 1) << 2) | (k & 2) | ((k >> 2) & 1)] = sr[k];
            ai[((k & 1) << 2) | (k & 2) | ((k >> 2) & 1)] = si[k];
        end
        for (int s = 0; s < 3; s++) begin
            h = 1 << s;
            for (int p = 0; p < 8; p++) begin
                if ((p & h) == 0) begin
                    q = p + h;
                    m = (p % h) * (4 / h);
                    qr = ar[q];
                    qi = ai[q];
                    if (m == 0) begin
                        tr = qr;
                        ti = qi;
                    end else if (m == 2) begin
                        tr = -qi;
                        ti = qr;
                    end else begin
                        cs = (m == 1) ? 181 : -181;
                        tr = ((qr * cs) >>> 8) - ((qi * 181) >>> 8);
                        ti = ((qr * 181) >>> 8) + ((qi * cs) >>> 8);
                    end
                    p_r = ar[p];
                    p_i = ai[p];
                    ar[p] = (p_r + tr) >>> 1;
                    ai[p] = (p_i + ti) >>> 1;
                    ar[q] = (p_r - tr) >>> 1;
                    ai[q] = (p_i - ti) >>> 1;
                end
            end
        end
        for (int n = 0; n < 8; n++) begin
            mr[n] = (ar[n] > 127) ? 127 : (ar[n] < -128) ? -128 : ar[n];
            mi[n] = (ai[n] > 127) ? 127 : (ai[n] < -128) ? -128 : ai[n];
        end
    endtask

    // Floating-point IDFT, clipped; outputs must stay within 4 LSB
    task automatic ideal_chk;
        real re, im, th;
        bit ok;
        ok = 1'b1;
        for (int n = 0; n < 8; n++) begin
            re = 0.0;
            im = 0.0;
            for (int k = 0; k < 8; k++) begin
                th = 2.0 * 3.14159265358979 * k * n / 8.0;
                re += sr[k] * $cos(th) - si[k] * $sin(th);
                im += sr[k] * $sin(th) + si[k] * $cos(th);
            end
            re = re / 8.0;
            im = im / 8.0;
            if (re > 127.0) re = 127.0;
            if (re < -128.0) re = -128.0;
            if (im > 127.0) im = 127.0;
            if (im < -128.0) im = -128.0;
            if (gr[n] - re > 4.0 || re - gr[n] > 4.0) ok = 1'b0;
            if (gi[n] - im > 4.0 || im - gi[n] > 4.0) ok = 1'b0;
        end
        chk("ideal_tol", int'(ok), 1);
    endtask

    task automatic cmp_model(input string nm);
        for (int n = 0; n < 8; n++) begin
            chk({nm, "_re"}, gr[n], mr[n]);
            chk({nm, "_im"}, gi[n], mi[n]);
        end
    endtask

    task automatic cmp_tbl(input int i, input string nm);
        for (int n = 0; n < 8; n++) begin
            chk({nm, "_re"}, gr[n], int'($signed(tbl[i].er[n])));
            chk({nm, "_im"}, gi[n], int'($signed(tbl[i].ei[n])));
        end
    endtask

    task automatic load_tbl(input int i);
        for (int k = 0; k < 8; k++) begin
            sr[k] = int'($signed(tbl[i].xr[k]));
            si[k] = int'($signed(tbl[i].xi[k]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit quiet;
        for (int i = 0; i < 4; i++) tbl[i] = '0;
        tbl[0].xr[0] = 8'd8;
        for (int n = 0; n < 8; n++) tbl[0].er[n] = 8'd1;
        for (int k = 0; k < 8; k++) tbl[1].xr[k] = 8'd8;
        tbl[1].er[0] = 8'd8;
        tbl[2].xr[2] = 8'd8;
        for (int n = 0; n < 8; n++) begin
            tbl[2].er[n] = 8'(sb_r[n]);
            tbl[2].ei[n] = 8'(sb_i[n]);
        end
        tbl[3].xr[0] = 8'd127;
        tbl[3].xr[4] = 8'h80;
        for (int n = 0; n < 8; n++)
            tbl[3].er[n] = (n % 2 == 0) ? 8'hFF : 8'd31;

        clear = 1'b1;
        in_valid = 1'b0;
        in_r = '0;
        in_im = '0;
        #12;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_r", int'(out_r), 0);
        chk("rst_out_im", int'(out_im), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_busy", int'(busy), 0);
        #1 clear = 1'b0;
        step;

        for (int i = 0; i < 4; i++) begin
            load_tbl(i);
            send(-1, 0, 8);
            chk("busy_compute", int'(busy), 1);
            collect(1'b0);
            cmp_tbl(i, $sformatf("tbl%0d", i));
        end

        load_tbl(0);
        send(3, 3, 8);
        collect(1'b1);
        cmp_tbl(0, "gap_impulse");

        for (int k = 0; k < 8; k++) begin
            sr[k] = 50;
            si[k] = -20;
        end
        send(-1, 0, 5);
        #1 clear = 1'b1;
        #2 clear = 1'b0;
        quiet = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step;
            if (out_valid || busy || !in_ready) quiet = 1'b0;
        end
        chk("clear_quiet", int'(quiet), 1);
        load_tbl(1);
        send(-1, 0, 8);
        collect(1'b0);
        cmp_tbl(1, "after_clear_dc");

        for (int k = 0; k < 8; k++) begin
            sr[k] = rt_r[k];
            si[k] = rt_i[k];
        end
        model;
        send(-1, 0, 8);
        collect(1'b0);
        cmp_model("roundtrip");
        begin
            bit ok;
            ok = 1'b1;
            for (int n = 0; n < 8; n++) begin
                if (gr[n] - rt_x[n] > 1 || rt_x[n] - gr[n] > 1) ok = 1'b0;
                if (gi[n] > 1 || gi[n] < -1) ok = 1'b0;
            end
            chk("roundtrip_1lsb", int'(ok), 1);
        end

        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < 8; k++) begin
                sr[k] = int'($urandom_range(255)) - 128;
                si[k] = int'($urandom_range(255)) - 128;
            end
            model;
            send((f % 3 == 0) ? int'($urandom_range(6)) : -1, 2, 8);
            collect(f[0]);
            cmp_model($sformatf("rand%0d", f));
            ideal_chk;
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
